// File: rtl/sequenciador_estados_if.sv
// Sequencer-to-datapath bundle: enable/opcode class in, phase code, strobes and status out.
// master = instruction-side driver, slave = the sequencer itself.
interface sequenciador_estados_if #(
    parameter int CNT_W = 16
) ();
    logic             run;
    logic [2:0]       tipo;
    logic [3:0]       estado;
    logic             irwrite;
    logic             pcwrite;
    logic             busy;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, tipo,
        input  estado, irwrite, pcwrite, busy, illegal, instr_count
    );

    modport slave (
        input  run, tipo,
        output estado, irwrite, pcwrite, busy, illegal, instr_count
    );
endinterface

// File: rtl/sequenciador_estados.sv
// Multicycle phase sequencer for the RISC-V datapath: emits the estado code, IR/PC strobes,
// a retired-instruction counter and a sticky halt on unsupported opcode classes.
//
// state  | meaning
// FETCH  | 0000 wait for run, IR load accepted on exit
// DECODE | 0001 capture opcode class, legality check
// EXEC   | 0010 control generator registers ALU controls
// ALU    | 0100 one cycle, branch to MEM for lw/sw
// MEM    | 0011 MEM_LAT cycles, down-counter paced
// WB     | 1111 two cycles, commit in the second
// HALT   | 1110 unsupported opcode, exits only on reset
module sequenciador_estados #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    sequenciador_estados_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'b0000,
        DECODE = 4'b0001,
        EXEC   = 4'b0010,
        ALU    = 4'b0100,
        MEM    = 4'b0011,
        WB     = 4'b1111,
        HALT   = 4'b1110
    } state_t;

    state_t           state;
    logic [2:0]       tipo_q;
    logic [3:0]       mem_cnt;
    logic             wb_last;
    logic             irwrite_q;
    logic             pcwrite_q;
    logic             busy_q;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             tipo_legal;

    assign tipo_legal = (bus.tipo == 3'b000) || (bus.tipo == 3'b001) ||
                        (bus.tipo == 3'b010) || (bus.tipo == 3'b011) ||
                        (bus.tipo == 3'b110);

    // Strobes are registered: irwrite is high for the cycle after an accepted FETCH,
    // pcwrite and the counter step land together in the second WB cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            tipo_q    <= 3'b000;
            mem_cnt   <= 4'd0;
            wb_last   <= 1'b0;
            irwrite_q <= 1'b0;
            pcwrite_q <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            irwrite_q <= 1'b0;
            pcwrite_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.run) begin
                        state     <= DECODE;
                        irwrite_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                DECODE: begin
                    tipo_q <= bus.tipo;
                    if (tipo_legal) begin
                        state <= EXEC;
                    end else begin
                        state     <= HALT;
                        illegal_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                EXEC: state <= ALU;
                ALU: begin
                    if (tipo_q == 3'b000 || tipo_q == 3'b010) begin
                        state   <= MEM;
                        mem_cnt <= 4'(MEM_LAT - 1);
                    end else begin
                        state   <= WB;
                        wb_last <= 1'b0;
                    end
                end
                MEM: begin
                    if (mem_cnt == 4'd0) begin
                        state   <= WB;
                        wb_last <= 1'b0;
                    end else begin
                        mem_cnt <= mem_cnt - 4'd1;
                    end
                end
                WB: begin
                    if (!wb_last) begin
                        wb_last   <= 1'b1;
                        pcwrite_q <= 1'b1;
                        count_q   <= count_q + 1'b1;
                    end else begin
                        wb_last <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= FETCH;
                    end
                end
                HALT: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= HALT;
                    busy_q    <= 1'b0;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.estado      = state;
    assign bus.irwrite     = irwrite_q;
    assign bus.pcwrite     = pcwrite_q;
    assign bus.busy        = busy_q;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = count_q;
endmodule
